key_event_detect: RTL

KEY_EVENT_DETECT -- requirements
Module: key_event_detect

---
 rtl/key_event_detect.sv | 132 +++++++++++++
 1 files changed

// File: rtl/key_event_detect.sv
// key_event_detect: classifies a debounced active-low key into short press, long press and
// double click events. All three events share one duration counter.
`timescale 1ns/1ps
`default_nettype none

module key_event_detect #(
    parameter int CNT_W    = 24,
    parameter int LONG_CNT = 10_000_000,
    parameter int GAP_CNT  = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             busy_q;
    logic             fall;

    assign fall = key_q & ~key;

    // The counter is cleared on every state change and compared before it
    // increments, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (!key) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end
            end
            WAIT2: begin
                // A second press wins over a gap timeout in the same cycle.
                if (!key) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESS2: begin
                if (key) begin
                    dbl_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (key) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // key_q resets to 1 so a key held low through reset reads as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b1;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire
